led_chaser_param: RTL and testbench

Parametrised multi-mode LED chaser for the board-level light-chaser display. It drives `NUM_LEDS` outputs with a programmable hold time per step and four run-time selectable patterns: rotate left, rotate right, bounce and bar-fill. It replaces the fixed 5-LED, fixed-delay, single-direction chaser as the front-panel pattern source. It also exports a step pulse, so neighbouring logic (buzzer, segment display) can stay in sync.

---
 rtl/led_chaser_pkg.sv | 14 +
 rtl/led_chaser_param_step_timer.sv | 35 +++
 rtl/led_chaser_param.sv | 100 ++++++++++
 tb/tb_led_chaser_param.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/led_chaser_pkg.sv
// rtl/led_chaser_pkg.sv - shared mode encodings and sizing helper for the LED chaser
package led_chaser_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    // Bar-fill needs pos to reach num_leds itself, hence the +1.
    function automatic int pos_width(input int num_leds);
        return $clog2(num_leds + 1);
    endfunction

endpackage

// File: rtl/led_chaser_param_step_timer.sv
// rtl/led_chaser_param_step_timer.sv - per-step hold counter producing the advance tick
module step_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] delay,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // delay is compared live, so lowering it below cnt forces an immediate advance.
    assign tick = enable && !clear && (cnt_q >= delay);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser_param.sv
// rtl/led_chaser_param.sv - multi-mode LED chaser: rotate left/right, bounce, bar-fill
module led_chaser_param #(
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    delay,
    output logic [NUM_LEDS-1:0] l,
    output logic                step,
    output logic                dir
);
    import led_chaser_pkg::*;

    localparam int PW = pos_width(NUM_LEDS);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(NUM_LEDS);

    logic [PW-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [1:0]          mode_q;
    logic                step_q;
    logic                restart;
    logic                tick;
    logic [NUM_LEDS-1:0] led_dec;

    // A mode change restarts the pattern and outranks any advance due this cycle.
    assign restart = (mode != mode_q);

    step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (restart),
        .delay  (delay),
        .tick   (tick)
    );

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (restart) begin
            pos_d = '0;
            dir_d = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dir_q && pos_q == POS_LAST) begin
                        pos_d = POS_LAST - POS_ONE;
                        dir_d = 1'b0;
                    end else if (!dir_q && pos_q == '0) begin
                        pos_d = POS_ONE;
                        dir_d = 1'b1;
                    end else if (dir_q) begin
                        pos_d = pos_q + POS_ONE;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                end
                MODE_FILL: pos_d = (pos_q == POS_FULL) ? '0 : pos_q + POS_ONE;
                default:   pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q  <= '0;
            dir_q  <= 1'b1;
            mode_q <= MODE_ROT_L;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode;
            step_q <= tick;
        end
    end

    always_comb begin
        led_dec = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q)
                MODE_ROT_R: led_dec[i] = (int'(pos_q) == NUM_LEDS - 1 - i);
                MODE_FILL:  led_dec[i] = (i < int'(pos_q));
                default:    led_dec[i] = (int'(pos_q) == i);
            endcase
        end
    end

    assign l    = led_dec;
    assign step = step_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_led_chaser_param.sv
// tb/tb_led_chaser_param.sv - scoreboard bench for led_chaser_param with NUM_LEDS=4
module tb_led_chaser_param;

    typedef struct {
        logic [3:0] l;
        logic       step;
        logic       dir;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] delay;
    logic [3:0] l;
    logic       step;
    logic       dir;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;

    led_chaser_param #(
        .NUM_LEDS (4),
        .CNT_W    (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .delay  (delay),
        .l      (l),
        .step   (step),
        .dir    (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] el, input logic es, input logic ed);
        checks++;
        if ({l, step, dir} !== {el, es, ed}) begin
            failures++;
            $display("FAIL %s: got l=%b step=%b dir=%b, expected l=%b step=%b dir=%b",
                     nm, l, step, dir, el, es, ed);
        end
    endtask

    // Wait for the next rising edge, then record what the outputs must show after it.
    task automatic cyc(input logic [3:0] el, input logic es, input logic ed, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.l = el; e.step = es; e.dir = ed; e.name = nm;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, mon_e.l, mon_e.step, mon_e.dir);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rotl [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] bnc_l [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic       bnc_d [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] fill [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001, 4'b0011};
        logic [3:0] prev;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        mode     = 2'd0;
        delay    = 8'd2;

        cyc(4'b0001, 1'b0, 1'b1, "reset_state");
        cyc(4'b0001, 1'b0, 1'b1, "reset_state");
        reset = 1'b0;

        prev = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            cyc(prev, 1'b0, 1'b1, "rotl_hold");
            cyc(prev, 1'b0, 1'b1, "rotl_hold");
            cyc(rotl[k], 1'b1, 1'b1, "rotl_step");
            prev = rotl[k];
        end

        mode  = 2'd2;
        delay = 8'd0;
        cyc(4'b0001, 1'b0, 1'b1, "bounce_restart");
        for (int k = 0; k < 7; k++) cyc(bnc_l[k], 1'b1, bnc_d[k], "bounce_step");

        mode = 2'd3;
        cyc(4'b0000, 1'b0, 1'b1, "fill_restart");
        for (int k = 0; k < 7; k++) cyc(fill[k], 1'b1, 1'b1, "fill_step");
        mode = 2'd1;
        cyc(4'b1000, 1'b0, 1'b1, "mode_change_restart");
        cyc(4'b0100, 1'b1, 1'b1, "rotr_first_step");

        delay = 8'd5;
        for (int k = 0; k < 3; k++) cyc(4'b0100, 1'b0, 1'b1, "freeze_prefill");
        enable = 1'b0;
        for (int k = 0; k < 10; k++) cyc(4'b0100, 1'b0, 1'b1, "freeze_hold");
        enable = 1'b1;
        cyc(4'b0100, 1'b0, 1'b1, "freeze_resume");
        cyc(4'b0100, 1'b0, 1'b1, "freeze_resume");
        cyc(4'b0010, 1'b1, 1'b1, "freeze_resume_step");

        delay = 8'd10;
        for (int k = 0; k < 7; k++) cyc(4'b0010, 1'b0, 1'b1, "live_delay_count");
        delay = 8'd4;
        cyc(4'b0001, 1'b1, 1'b1, "live_delay_early_step");
        for (int k = 0; k < 4; k++) cyc(4'b0001, 1'b0, 1'b1, "live_delay_hold");
        cyc(4'b1000, 1'b1, 1'b1, "live_delay_step");

        mode  = 2'd2;
        delay = 8'd0;
        cyc(4'b0001, 1'b0, 1'b1, "bounce2_restart");
        cyc(4'b0010, 1'b1, 1'b1, "bounce2_step");
        cyc(4'b0100, 1'b1, 1'b1, "bounce2_step");
        cyc(4'b1000, 1'b1, 1'b1, "bounce2_step");
        cyc(4'b0100, 1'b1, 1'b0, "bounce2_down");
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", 4'b0001, 1'b0, 1'b1);
        cyc(4'b0001, 1'b0, 1'b1, "async_reset_held");
        reset = 1'b0;
        cyc(4'b0001, 1'b0, 1'b1, "post_reset_restart");
        cyc(4'b0010, 1'b1, 1'b1, "post_reset_step");

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
